fir_mac_engine: RTL and testbench
=================================

Name: fir_mac_engine

Overview:
- Single-rate FIR compute engine that reads coefficients through the read-only port of the 128x18 coefficient dual-port RAM.
- Per accepted input sample it sweeps all taps: it issues coefficient addresses, multiplies each returned coefficient with the matching sample from an internal sample history, and accumulates.
- It emits one rounded, saturated 18-bit output per input sample.
- Sits between the sample source and the output stage; the host keeps ownership of the coefficient RAM's read/write port.

Parameters:
- NTAPS, 128: number of taps; power of two; equals coefficient RAM depth.
- DW, 18: sample, coefficient and output width; signed two's complement; coefficients Q1.17.
- AW, 7: address width, log2(NTAPS).
- ACCW, 44: accumulator width (2*DW+AW+1).

Ports:
- clock  in  1  system clock; all logic on the rising edge.
- reset  in  1  synchronous, active-high reset.
- din_valid  in  1  input sample valid.
- din  in  DW  signed input sample.
- din_ready  out  1  engine can accept a sample.
- coef_addr  out  AW  coefficient RAM read address (RAM port 2).
- coef_data  in  DW  coefficient RAM read data; registered, valid one cycle after coef_addr.
- dout_valid  out  1  one-cycle pulse; dout holds a new result.
- dout  out  DW  signed filtered output; held until the next result.
- busy  out  1  high in every state except IDLE.

Behaviour:
- Reset: state=CLEAR, din_ready=0, dout_valid=0, dout=0, coef_addr=0, accumulator=0, write pointer wptr=0, sweep counter k=0. Reset asserted in any state, including mid-MAC, aborts the operation; the partial result is discarded.
- States and transitions:
  - CLEAR: writes 0 to history[k], k=0..NTAPS-1, one entry per cycle. Goes to IDLE after NTAPS cycles.
  - IDLE: din_ready=1. When din_valid&&din_ready at cycle T: history[wptr]<=din, capture base=wptr, wptr<=wptr+1 mod NTAPS, acc<=0, k<=0, go to MAC.
  - MAC: runs cycles T+1..T+NTAPS. coef_addr=k; sample read index=(base-k) mod NTAPS, registered with the same 1-cycle latency as the RAM. k increments each cycle. After k=NTAPS-1, go to DRAIN.
  - DRAIN: cycle T+NTAPS+1; the final product is accumulated. Go to OUT.
  - OUT: cycle T+NTAPS+2; dout<=sat(scale(acc)), dout_valid=1, go to IDLE.
- Accumulation rule: acc<=acc+coef_data*sample_q, applied on cycles T+2..T+NTAPS+1 (pipeline-valid flag delayed one cycle from address issue). Full-precision signed product, sign-extended to ACCW.
- Latency: din accepted at T produces dout_valid at T+NTAPS+2. Throughput is one sample per NTAPS+3 cycles (IDLE cycle included).
- Scale: result = acc>>>17 (arithmetic). Saturate to [-2^17, 2^17-1]: 0x20000 and 0x1FFFF.
- Wrap-around: wptr and the read index are modulo NTAPS. The history after CLEAR is all zeros, so the first NTAPS outputs see zero-padded history.
- din_valid while not IDLE: ignored. The source must hold din/din_valid until the handshake.
- Simultaneous reset and handshake: reset wins; the sample is not stored.
- coef_addr holds its last value outside MAC.
- The engine never writes the coefficient RAM.

Optional Feature:
- FIR_ROUND_EN
  - Defined: before the shift, add 2^16 to acc (round half up), then saturate.
  - Undefined: plain truncation by arithmetic shift.
- The addition is performed in ACCW+1 bits so it cannot overflow.

Decomposition:
- Package fir_pkg: DW, AW, NTAPS, ACCW, FRAC=17, SAT_MAX/SAT_MIN constants, state enum {CLEAR, IDLE, MAC, DRAIN, OUT}.
- Sub-module fir_sample_ring: NTAPS x DW history.
  - 1 write port (used by CLEAR zeros or IDLE sample).
  - 1 registered read port with 1-cycle latency.
  - Inferable as block RAM.

Test Plan:
- Reset then CLEAR: din_ready stays 0 for exactly 128 cycles, then rises. Outputs stay 0 throughout.
- Impulse: coef[0]=0x10000, all others 0; din=0x08000 -> dout=0x04000 with dout_valid at T+130. Next din=0 -> dout=0.
- Delay line: coef[1]=0x10000, all others 0; din sequence 0x08000, 0 -> dout 0, then 0x04000. Feed 130 samples to cross the wptr wrap; the output must keep tracking the previous sample.
- Saturation: all coef=0x1FFFF, feed 128 samples of 0x1FFFF -> dout=0x1FFFF. All coef=0x20000 with the same samples -> dout=0x20000.
- Rounding: coef[0]=0x00001, din=0x10000 -> dout=0x00000 without FIR_ROUND_EN, 0x00001 with it.
- Abort: assert reset at T+50 -> dout_valid never pulses; state returns to CLEAR; history is zeroed. A subsequent impulse gives the clean impulse result.

Source files
------------

// File: rtl/fir_mac_engine_pkg.sv
// fir_pkg: shared widths, saturation limits, FSM state type and output scaling.
// FIR_ROUND_EN selects round-half-up instead of truncation in scale_sat().
package fir_pkg;

    localparam int NTAPS = 128;
    localparam int DW    = 18;
    localparam int AW    = 7;
    localparam int ACCW  = 2 * DW + AW + 1;
    localparam int FRAC  = 17;

    localparam logic [DW-1:0] SAT_MAX = 18'h1FFFF;
    localparam logic [DW-1:0] SAT_MIN = 18'h20000;

    localparam int SAT_HI = 2 ** (DW - 1) - 1;
    localparam int SAT_LO = -(2 ** (DW - 1));

    localparam logic signed [ACCW:0] LIM_HI = (ACCW + 1)'(SAT_HI);
    localparam logic signed [ACCW:0] LIM_LO = (ACCW + 1)'(SAT_LO);
    localparam logic signed [ACCW:0] RND    = (ACCW + 1)'(2 ** (FRAC - 1));

    typedef enum logic [2:0] {
        CLEAR,
        IDLE,
        MAC,
        DRAIN,
        OUT
    } state_t;

    // One extra bit of headroom so the rounding add can never wrap.
    function automatic logic [DW-1:0] scale_sat(input logic signed [ACCW-1:0] a);
        logic signed [ACCW:0] e;
        logic signed [ACCW:0] s;
        e = {a[ACCW-1], a};
`ifdef FIR_ROUND_EN
        e = e + RND;
`endif
        s = e >>> FRAC;
        if (s > LIM_HI) begin
            return SAT_MAX;
        end else if (s < LIM_LO) begin
            return SAT_MIN;
        end
        return s[DW-1:0];
    endfunction

endpackage

// File: rtl/fir_mac_engine_if.sv
// fir_mac_engine_if: sample in, coefficient read port, result out, busy.
// master = source/RAM/sink side, slave = engine side.
interface fir_mac_engine_if;
    import fir_pkg::*;

    logic          din_valid;
    logic [DW-1:0] din;
    logic          din_ready;
    logic [AW-1:0] coef_addr;
    logic [DW-1:0] coef_data;
    logic          dout_valid;
    logic [DW-1:0] dout;
    logic          busy;

    modport master (
        output din_valid, din, coef_data,
        input  din_ready, coef_addr, dout_valid, dout, busy
    );

    modport slave (
        input  din_valid, din, coef_data,
        output din_ready, coef_addr, dout_valid, dout, busy
    );

endinterface

// File: rtl/fir_sample_ring.sv
// fir_sample_ring: NTAPS x DW sample history, one write port and one
// registered read port (1-cycle latency); ports clock, we/waddr/wdata, raddr/rdata.
module fir_sample_ring
    import fir_pkg::*;
(
    input  logic          clock,
    input  logic          we,
    input  logic [AW-1:0] waddr,
    input  logic [DW-1:0] wdata,
    input  logic [AW-1:0] raddr,
    output logic [DW-1:0] rdata
);

    logic [DW-1:0] mem [NTAPS];

    always_ff @(posedge clock) begin
        if (we) begin
            mem[waddr] <= wdata;
        end
        rdata <= mem[raddr];
    end

endmodule

// File: rtl/fir_mac_engine.sv
// fir_mac_engine: one FIR output per sample, sweeping NTAPS taps through the
// coefficient RAM read port; ports clock, reset, bus (slave). Macro: FIR_ROUND_EN.
module fir_mac_engine
    import fir_pkg::*;
(
    input  logic             clock,
    input  logic             reset,
    fir_mac_engine_if.slave  bus
);

    state_t                 state;
    logic [AW-1:0]          k;
    logic [AW-1:0]          wptr;
    logic [AW-1:0]          base;
    logic [AW-1:0]          coef_addr_q;
    logic signed [ACCW-1:0] acc;
    logic                   pv;
    logic                   din_ready_q;
    logic                   dout_valid_q;
    logic [DW-1:0]          dout_q;
    logic                   busy_q;

    logic                   take;
    logic                   ring_we;
    logic [AW-1:0]          ring_waddr;
    logic [DW-1:0]          ring_wdata;
    logic [AW-1:0]          ring_raddr;
    logic [DW-1:0]          ring_rdata;

    logic signed [DW-1:0]     cs;
    logic signed [DW-1:0]     hs;
    logic signed [2*DW-1:0]   prod;
    logic signed [ACCW-1:0]   prod_x;

    assign take = (state == IDLE) && bus.din_valid && din_ready_q;

    // Reset must win over a same-cycle handshake, so the write is gated too.
    assign ring_we    = !reset && ((state == CLEAR) || take);
    assign ring_waddr = (state == CLEAR) ? k : wptr;
    assign ring_wdata = (state == CLEAR) ? '0 : bus.din;
    assign ring_raddr = base - k;

    fir_sample_ring u_ring (
        .clock (clock),
        .we    (ring_we),
        .waddr (ring_waddr),
        .wdata (ring_wdata),
        .raddr (ring_raddr),
        .rdata (ring_rdata)
    );

    assign cs     = bus.coef_data;
    assign hs     = ring_rdata;
    assign prod   = (2 * DW)'(cs) * (2 * DW)'(hs);
    assign prod_x = $signed({{(ACCW - 2 * DW){prod[2*DW-1]}}, prod});

    always_ff @(posedge clock) begin
        if (reset) begin
            state        <= CLEAR;
            k            <= '0;
            wptr         <= '0;
            base         <= '0;
            coef_addr_q  <= '0;
            acc          <= '0;
            pv           <= 1'b0;
            din_ready_q  <= 1'b0;
            dout_valid_q <= 1'b0;
            dout_q       <= '0;
            busy_q       <= 1'b1;
        end else begin
            dout_valid_q <= 1'b0;
            // RAM and ring both return data one cycle after the address.
            pv <= (state == MAC);
            if (pv) begin
                acc <= acc + prod_x;
            end
            unique case (state)
                CLEAR: begin
                    k <= k + 1'b1;
                    if (k == AW'(NTAPS - 1)) begin
                        state       <= IDLE;
                        din_ready_q <= 1'b1;
                        busy_q      <= 1'b0;
                    end
                end
                IDLE: begin
                    if (take) begin
                        base        <= wptr;
                        wptr        <= wptr + 1'b1;
                        acc         <= '0;
                        k           <= '0;
                        coef_addr_q <= '0;
                        din_ready_q <= 1'b0;
                        busy_q      <= 1'b1;
                        state       <= MAC;
                    end
                end
                MAC: begin
                    k <= k + 1'b1;
                    if (k == AW'(NTAPS - 1)) begin
                        state <= DRAIN;
                    end else begin
                        coef_addr_q <= k + 1'b1;
                    end
                end
                DRAIN: begin
                    state <= OUT;
                end
                OUT: begin
                    dout_q       <= scale_sat(acc);
                    dout_valid_q <= 1'b1;
                    din_ready_q  <= 1'b1;
                    busy_q       <= 1'b0;
                    state        <= IDLE;
                end
                default: begin
                    state <= CLEAR;
                end
            endcase
        end
    end

    assign bus.din_ready  = din_ready_q;
    assign bus.coef_addr  = coef_addr_q;
    assign bus.dout_valid = dout_valid_q;
    assign bus.dout       = dout_q;
    assign bus.busy       = busy_q;

endmodule

// File: tb/tb_fir_mac_engine.sv
// tb_fir_mac_engine: directed bench for fir_mac_engine with a registered
// coefficient RAM model; honours FIR_ROUND_EN for the rounding case.
module tb_fir_mac_engine;

    logic clock;
    logic reset;
    int   errors;
    int   checks;

    logic [17:0] coef_mem [128];

    fir_mac_engine_if bus ();

    fir_mac_engine dut (
        .clock (clock),
        .reset (reset),
        .bus   (bus)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    always @(posedge clock) bus.coef_data <= coef_mem[bus.coef_addr];

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic set_coefs(input logic [17:0] all, input logic [17:0] c0, input logic [17:0] c1);
        for (int i = 0; i < 128; i++) coef_mem[i] = all;
        coef_mem[0] = c0;
        coef_mem[1] = c1;
    endtask

    task automatic send(input logic [17:0] s, input logic [17:0] exp,
                        input string tag, input bit do_val);
        int n;
        n = 0;
        while (!bus.din_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_ready"}, 32'(bus.din_ready), 32'd1);
        bus.din       = s;
        bus.din_valid = 1'b1;
        @(negedge clock);
        bus.din_valid = 1'b0;
        chk({tag, "_busy"}, 32'(bus.busy), 32'd1);
        n = 0;
        while (!bus.dout_valid && n < 200) begin
            @(negedge clock);
            n++;
        end
        chk({tag, "_lat"}, 32'(n), 32'd130);
        if (do_val) chk({tag, "_dout"}, 32'(bus.dout), 32'(exp));
    endtask

    initial begin
        int n;
        int v;
        int prev;
        int pulses;
        bit dirty;
        logic [17:0] s;
        logic [17:0] e;
        errors = 0;
        checks = 0;
        reset  = 1'b1;
        bus.din_valid = 1'b0;
        bus.din       = '0;
        set_coefs(18'h0, 18'h0, 18'h0);
        repeat (3) @(negedge clock);

        chk("rst_ready", 32'(bus.din_ready), 32'd0);
        chk("rst_dvalid", 32'(bus.dout_valid), 32'd0);
        chk("rst_dout", 32'(bus.dout), 32'd0);
        chk("rst_busy", 32'(bus.busy), 32'd1);
        chk("rst_addr", 32'(bus.coef_addr), 32'd0);

        reset = 1'b0;
        n = 0;
        dirty = 1'b0;
        do begin
            @(negedge clock);
            n++;
            if (bus.dout_valid || bus.dout != 18'h0) dirty = 1'b1;
        end while (!bus.din_ready && n < 300);
        chk("clear_len", 32'(n), 32'd128);
        chk("clear_quiet", 32'(dirty), 32'd0);
        chk("idle_busy", 32'(bus.busy), 32'd0);

        // Impulse through tap 0 (0.5)
        set_coefs(18'h0, 18'h10000, 18'h0);
        send(18'h08000, 18'h04000, "imp1", 1'b1);
        send(18'h00000, 18'h00000, "imp0", 1'b1);

        // One-sample delay through tap 1, across the pointer wrap
        set_coefs(18'h0, 18'h0, 18'h10000);
        send(18'h08000, 18'h00000, "dly_a", 1'b1);
        send(18'h00000, 18'h04000, "dly_b", 1'b1);
        prev = 0;
        for (int i = 0; i < 130; i++) begin
            v = i * 512 - 30000;
            s = v[17:0];
            e = 18'(prev / 2);
            send(s, e, "dly_wrap", 1'b1);
            prev = v;
        end

        // Positive and negative saturation with a full history
        set_coefs(18'h1FFFF, 18'h1FFFF, 18'h1FFFF);
        for (int i = 0; i < 128; i++) begin
            send(18'h1FFFF, 18'h1FFFF, "sat_pos", i == 127);
        end
        set_coefs(18'h20000, 18'h20000, 18'h20000);
        send(18'h1FFFF, 18'h20000, "sat_neg", 1'b1);

        // Half-LSB product
        set_coefs(18'h0, 18'h00001, 18'h0);
`ifdef FIR_ROUND_EN
        send(18'h10000, 18'h00001, "round", 1'b1);
`else
        send(18'h10000, 18'h00000, "round", 1'b1);
`endif

        // Abort mid-MAC: no result, history cleared, then a clean impulse
        set_coefs(18'h0, 18'h10000, 18'h10000);
        n = 0;
        while (!bus.din_ready && n < 400) begin
            @(negedge clock);
            n++;
        end
        bus.din       = 18'h08000;
        bus.din_valid = 1'b1;
        @(negedge clock);
        bus.din_valid = 1'b0;
        pulses = 0;
        repeat (49) begin
            @(negedge clock);
            if (bus.dout_valid) pulses++;
        end
        reset = 1'b1;
        @(negedge clock);
        reset = 1'b0;
        chk("abort_busy", 32'(bus.busy), 32'd1);
        chk("abort_ready", 32'(bus.din_ready), 32'd0);
        n = 0;
        repeat (300) begin
            @(negedge clock);
            if (bus.dout_valid) pulses++;
            if (!bus.din_ready) n++;
        end
        chk("abort_pulse", 32'(pulses), 32'd0);
        chk("abort_clear", 32'(n), 32'd127);
        send(18'h08000, 18'h04000, "abort_imp", 1'b1);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
